// File: rtl/l1_refill_ctrl_if.sv
// Signal bundle between the L1 miss path, the memory bus and the L1 refill engine.
// master = refill engine, slave = the L1 / memory side it connects.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

interface l1_refill_ctrl_if #(
    parameter int XPR_LEN    = `XPR_LEN,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic               miss_valid;
    logic [ADDR_W-1:0]  miss_addr;
    logic               miss_ready;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;

    logic               mem_resp_valid;
    logic [XPR_LEN-1:0] mem_resp_data;
    logic               mem_resp_err;

    logic               fill_we;
    logic [IDX_W-1:0]   fill_idx;
    logic [XPR_LEN-1:0] fill_data;
    logic [ADDR_W-1:0]  fill_line_addr;

    logic               crit_valid;
    logic [XPR_LEN-1:0] crit_data;
    logic               done;
    logic               err;

    modport master (
        input  miss_valid, miss_addr,
        output miss_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_err,
        output fill_we, fill_idx, fill_data, fill_line_addr,
        output crit_valid, crit_data, done, err
    );

    modport slave (
        output miss_valid, miss_addr,
        input  miss_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_err,
        input  fill_we, fill_idx, fill_data, fill_line_addr,
        input  crit_valid, crit_data, done, err
    );
endinterface

// File: rtl/l1_refill_ctrl.sv
// L1 line-refill engine: one burst read per miss, registered word fills, early critical word.
// Optional feature macro: L1_REFILL_CRIT_WORD_FIRST_EN (request and fill start at the critical word).
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module l1_refill_ctrl #(
    parameter int XPR_LEN    = `XPR_LEN,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    l1_refill_ctrl_if.master  bus
);
    localparam int OFF_W = $clog2(XPR_LEN / 8);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int LOW_W = OFF_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [ADDR_W-1:0]  r_line_base;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [IDX_W-1:0]   r_crit_idx;
    logic [IDX_W-1:0]   r_start_idx;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_err_flag;
    logic               r_fill_we;
    logic [IDX_W-1:0]   r_fill_idx;
    logic [XPR_LEN-1:0] r_fill_data;
    logic               r_crit_valid;
    logic [XPR_LEN-1:0] r_crit_data;

    logic               w_accept;
    logic               w_beat;
    logic               w_beat_err;
    logic [IDX_W-1:0]   w_beat_idx;
    logic [ADDR_W-1:0]  w_miss_base;
    logic [IDX_W-1:0]   w_miss_crit;
    logic [ADDR_W-1:0]  w_req_addr;
    logic [IDX_W-1:0]   w_start_idx;
    logic               w_unused_addr;

    assign w_accept    = (r_state == S_IDLE) && bus.miss_valid;
    assign w_beat      = (r_state == S_RESP) && bus.mem_resp_valid;
    assign w_beat_err  = r_err_flag || bus.mem_resp_err;
    assign w_beat_idx  = r_start_idx + r_cnt;  // wraps modulo LINE_WORDS
    assign w_miss_base = {bus.miss_addr[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
    assign w_miss_crit = bus.miss_addr[LOW_W-1:OFF_W];
    assign w_unused_addr = &{1'b0, bus.miss_addr};

`ifdef L1_REFILL_CRIT_WORD_FIRST_EN
    assign w_req_addr  = w_miss_base | (ADDR_W'(w_miss_crit) << OFF_W);
    assign w_start_idx = w_miss_crit;
`else
    assign w_req_addr  = w_miss_base;
    assign w_start_idx = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: default assignment first so no path leaves the combinational output unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.miss_valid)    w_next_state = S_REQ;
            S_REQ:   if (bus.mem_req_ready) w_next_state = S_RESP;
            S_RESP:  if (w_beat && (r_cnt == LAST_CNT)) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.miss_ready    = (r_state == S_IDLE);
        bus.mem_req_valid = (r_state == S_REQ);
        bus.done          = (r_state == S_DONE);
        bus.err           = (r_state == S_DONE) && r_err_flag;
    end

    assign bus.mem_req_addr   = r_req_addr;
    assign bus.fill_line_addr = r_line_base;
    assign bus.fill_we        = r_fill_we;
    assign bus.fill_idx       = r_fill_idx;
    assign bus.fill_data      = r_fill_data;
    assign bus.crit_valid     = r_crit_valid;
    assign bus.crit_data      = r_crit_data;

    // Once a beat errors, it and every later beat are consumed without writing the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_base  <= '0;
            r_req_addr   <= '0;
            r_crit_idx   <= '0;
            r_start_idx  <= '0;
            r_cnt        <= '0;
            r_err_flag   <= 1'b0;
            r_fill_we    <= 1'b0;
            r_fill_idx   <= '0;
            r_fill_data  <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
        end else begin
            r_fill_we    <= 1'b0;
            r_crit_valid <= 1'b0;
            if (w_accept) begin
                r_line_base <= w_miss_base;
                r_req_addr  <= w_req_addr;
                r_crit_idx  <= w_miss_crit;
                r_start_idx <= w_start_idx;
                r_cnt       <= '0;
                r_err_flag  <= 1'b0;
            end
            if (w_beat) begin
                r_cnt      <= r_cnt + 1'b1;
                r_err_flag <= w_beat_err;
                if (!w_beat_err) begin
                    r_fill_we   <= 1'b1;
                    r_fill_idx  <= w_beat_idx;
                    r_fill_data <= bus.mem_resp_data;
                    if (w_beat_idx == r_crit_idx) begin
                        r_crit_valid <= 1'b1;
                        r_crit_data  <= bus.mem_resp_data;
                    end
                end
            end
        end
    end
endmodule
